// File: rtl/cdp_dp_intp_lanes.sv
// ---------------------------------------------------------------------------
// cdp_dp_intp_lanes
// Multi-lane linear interpolation datapath for the CDP block. Each beat
// carries LANES independent (x0, x1, base) triples plus a shared scale,
// shift and rounding mode. Per lane:
//   out = sat_OW( round((x1 - x0) * scale >> shift) + base )
// or, in bypass mode, out = sat_OW(base).
// Three pipeline stages (S0 subtract, S1 multiply, S2 shift/round/add/clip)
// share one valid/ready handshake with a combinational ready chain, so the
// pipe sustains one beat per cycle.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   intp_in_vld / intp_in_rdy        : input beat handshake
//   intp_in_x0 / intp_in_x1          : per-lane signed operands (LANES*DW)
//   intp_in_base                     : per-lane signed base (LANES*BW)
//   intp_in_scale                    : shared signed fraction (BW)
//   intp_in_shift                    : signed shift, >=0 right, <0 left
//   intp_in_rnd                      : 0 half-away, 1 floor, 2 half-even
//   intp_in_bypass                   : result = sat(base)
//   intp_out_vld / intp_out_rdy      : output beat handshake
//   intp_out_pd                      : per-lane saturated results (LANES*OW)
//   sat_cnt_clr / sat_cnt            : saturation event counter and clear
// ---------------------------------------------------------------------------
module cdp_dp_intp_lanes #(
  parameter int LANES = 4,
  parameter int DW    = 39,
  parameter int BW    = 17,
  parameter int OW    = 16
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  intp_in_vld,
  output logic                  intp_in_rdy,
  input  logic [LANES*DW-1:0]   intp_in_x0,
  input  logic [LANES*DW-1:0]   intp_in_x1,
  input  logic [LANES*BW-1:0]   intp_in_base,
  input  logic [BW-1:0]         intp_in_scale,
  input  logic [5:0]            intp_in_shift,
  input  logic [1:0]            intp_in_rnd,
  input  logic                  intp_in_bypass,
  output logic                  intp_out_vld,
  input  logic                  intp_out_rdy,
  output logic [LANES*OW-1:0]   intp_out_pd,
  input  logic                  sat_cnt_clr,
  output logic [31:0]           sat_cnt
);

  localparam int SW = DW + 1;          // x1 - x0 never overflows here
  localparam int MW = DW + BW + 1;     // exact product width
  localparam int WW = MW + 32;         // product after a full 32-bit left shift
  localparam int CW = $clog2(LANES + 1);

  localparam logic [WW-1:0]        ONE  = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0]        ZERO = {WW{1'b0}};
  localparam logic signed [WW:0]   SMAX = {{(WW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [WW:0]   SMIN = {{(WW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  // Shift/round/add/clip for one lane; returns {saturated, result}.
  function automatic logic [OW:0] lane_calc(
    input logic signed [MW-1:0] mul,
    input logic [5:0]           sh,
    input logic [1:0]           rnd,
    input logic                 byp,
    input logic signed [BW-1:0] base
  );
    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] shifted;
    logic [WW-1:0]        mask;
    logic [WW-1:0]        frac;
    logic [WW-1:0]        half;
    logic [5:0]           amt;
    logic                 inc;
    logic signed [WW:0]   sum;
    logic [OW:0]          res;
    ext = {{(WW-MW){mul[MW-1]}}, mul};
    if (sh[5]) begin
      // left shift: value is exact in WW bits, nothing to round
      amt     = 6'd0 - sh;
      shifted = ext <<< amt;
      mask    = ZERO;
      frac    = ZERO;
      half    = ZERO;
      inc     = 1'b0;
    end else begin
      amt     = sh;
      shifted = ext >>> amt;
      mask    = (ONE << amt) - ONE;
      frac    = ext & mask;
      half    = (amt == 6'd0) ? ZERO : (ONE << (amt - 6'd1));
      if (amt == 6'd0) begin
        inc = 1'b0;
      end else begin
        case (rnd)
          2'd1:    inc = 1'b0;
          2'd2:    inc = (frac > half) | ((frac == half) & shifted[0]);
          // floor already moved negatives down, so a tie only bumps positives
          default: inc = (frac > half) | ((frac == half) & ~mul[MW-1]);
        endcase
      end
    end
    if (byp) begin
      sum = {{(WW+1-BW){base[BW-1]}}, base};
    end else begin
      sum = {shifted[WW-1], shifted} + {{(WW+1-BW){base[BW-1]}}, base}
          + {{WW{1'b0}}, inc};
    end
    if (sum > SMAX) begin
      res = {1'b1, 1'b0, {(OW-1){1'b1}}};
    end else if (sum < SMIN) begin
      res = {1'b1, 1'b1, {(OW-1){1'b0}}};
    end else begin
      res = {1'b0, sum[OW-1:0]};
    end
    return res;
  endfunction

  logic                 r_vld_s0, r_vld_s1, r_vld_s2;
  logic [LANES*SW-1:0]  r_sub_s0;
  logic [BW-1:0]        r_scale_s0;
  logic [5:0]           r_shift_s0, r_shift_s1;
  logic [1:0]           r_rnd_s0, r_rnd_s1;
  logic                 r_byp_s0, r_byp_s1;
  logic [LANES*BW-1:0]  r_base_s0, r_base_s1;
  logic [LANES*MW-1:0]  r_mul_s1;
  logic [LANES*OW-1:0]  r_pd_s2;
  logic [CW-1:0]        r_nsat_s2;
  logic [31:0]          r_sat_cnt;

  logic                 w_rdy_s1, w_rdy_s0;
  logic                 w_ld_s0, w_ld_s1, w_ld_s2, w_out_fire;
  logic [LANES*SW-1:0]  w_sub;
  logic [LANES*MW-1:0]  w_mul;
  logic [LANES*OW-1:0]  w_pd;
  logic [CW-1:0]        w_nsat;
  logic [OW:0]          w_res;
  logic [32:0]          w_cnt_sum;

  // ready ripples back combinationally so a full pipe still advances each cycle
  assign w_rdy_s1    = ~r_vld_s2 | intp_out_rdy;
  assign w_rdy_s0    = ~r_vld_s1 | w_rdy_s1;
  assign intp_in_rdy = ~r_vld_s0 | w_rdy_s0;
  assign w_ld_s0     = intp_in_vld & intp_in_rdy;
  assign w_ld_s1     = r_vld_s0 & w_rdy_s0;
  assign w_ld_s2     = r_vld_s1 & w_rdy_s1;
  assign w_out_fire  = r_vld_s2 & intp_out_rdy;
  assign w_cnt_sum   = {1'b0, r_sat_cnt} + {{(33-CW){1'b0}}, r_nsat_s2};

  // Per-lane subtract (S0 input) and multiply (S1 input).
  always_comb begin
    w_sub = {(LANES*SW){1'b0}};
    w_mul = {(LANES*MW){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w_sub[i*SW +: SW] = {intp_in_x1[i*DW+DW-1], intp_in_x1[i*DW +: DW]}
                        - {intp_in_x0[i*DW+DW-1], intp_in_x0[i*DW +: DW]};
      w_mul[i*MW +: MW] = $signed({{(MW-SW){r_sub_s0[i*SW+SW-1]}}, r_sub_s0[i*SW +: SW]})
                        * $signed({{(MW-BW){r_scale_s0[BW-1]}}, r_scale_s0});
    end
  end

  // Per-lane S2 result and count of lanes that clipped.
  always_comb begin
    w_pd   = {(LANES*OW){1'b0}};
    w_nsat = {CW{1'b0}};
    w_res  = {(OW+1){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w_res = lane_calc(r_mul_s1[i*MW +: MW], r_shift_s1, r_rnd_s1, r_byp_s1,
                        r_base_s1[i*BW +: BW]);
      w_pd[i*OW +: OW] = w_res[OW-1:0];
      w_nsat = w_nsat + {{(CW-1){1'b0}}, w_res[OW]};
    end
  end

  // Stage valids: set on load, clear only when taken without a refill.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_vld_s0 <= 1'b0;
      r_vld_s1 <= 1'b0;
      r_vld_s2 <= 1'b0;
    end else begin
      if (w_ld_s0 | w_ld_s1)    r_vld_s0 <= w_ld_s0;
      if (w_ld_s1 | w_ld_s2)    r_vld_s1 <= w_ld_s1;
      if (w_ld_s2 | w_out_fire) r_vld_s2 <= w_ld_s2;
    end
  end

  // Datapath registers; each stage holds its data until it loads again.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_sub_s0   <= {(LANES*SW){1'b0}};
      r_scale_s0 <= {BW{1'b0}};
      r_shift_s0 <= 6'd0;
      r_rnd_s0   <= 2'd0;
      r_byp_s0   <= 1'b0;
      r_base_s0  <= {(LANES*BW){1'b0}};
      r_mul_s1   <= {(LANES*MW){1'b0}};
      r_shift_s1 <= 6'd0;
      r_rnd_s1   <= 2'd0;
      r_byp_s1   <= 1'b0;
      r_base_s1  <= {(LANES*BW){1'b0}};
      r_pd_s2    <= {(LANES*OW){1'b0}};
      r_nsat_s2  <= {CW{1'b0}};
    end else begin
      if (w_ld_s0) begin
        r_sub_s0   <= w_sub;
        r_scale_s0 <= intp_in_scale;
        r_shift_s0 <= intp_in_shift;
        r_rnd_s0   <= intp_in_rnd;
        r_byp_s0   <= intp_in_bypass;
        r_base_s0  <= intp_in_base;
      end
      if (w_ld_s1) begin
        r_mul_s1   <= w_mul;
        r_shift_s1 <= r_shift_s0;
        r_rnd_s1   <= r_rnd_s0;
        r_byp_s1   <= r_byp_s0;
        r_base_s1  <= r_base_s0;
      end
      if (w_ld_s2) begin
        r_pd_s2    <= w_pd;
        r_nsat_s2  <= w_nsat;
      end
    end
  end

  // Saturation counter: clear beats increment, saturates at all-ones.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_sat_cnt <= 32'd0;
    end else if (sat_cnt_clr) begin
      r_sat_cnt <= 32'd0;
    end else if (w_out_fire) begin
      r_sat_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
    end else begin
      r_sat_cnt <= r_sat_cnt;
    end
  end

  assign intp_out_vld = r_vld_s2;
  assign intp_out_pd  = r_pd_s2;
  assign sat_cnt      = r_sat_cnt;

endmodule

// File: tb/tb_cdp_dp_intp_lanes.sv
// ---------------------------------------------------------------------------
// tb_cdp_dp_intp_lanes
// Directed bench for cdp_dp_intp_lanes: a table of single-beat vectors with
// hand-computed lane-0 results, followed by sequences for back-pressure,
// counter clear collision and mid-flight reset.
// ---------------------------------------------------------------------------
module tb_cdp_dp_intp_lanes;

  localparam int LANES = 4;
  localparam int DW    = 39;
  localparam int BW    = 17;
  localparam int OW    = 16;

  logic                clk;
  logic                rst_n;
  logic                in_vld;
  logic                in_rdy;
  logic [LANES*DW-1:0] in_x0;
  logic [LANES*DW-1:0] in_x1;
  logic [LANES*BW-1:0] in_base;
  logic [BW-1:0]       in_scale;
  logic [5:0]          in_shift;
  logic [1:0]          in_rnd;
  logic                in_byp;
  logic                out_vld;
  logic                out_rdy;
  logic [LANES*OW-1:0] out_pd;
  logic                cnt_clr;
  logic [31:0]         cnt;

  cdp_dp_intp_lanes #(.LANES(LANES), .DW(DW), .BW(BW), .OW(OW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .intp_in_vld     (in_vld),
    .intp_in_rdy     (in_rdy),
    .intp_in_x0      (in_x0),
    .intp_in_x1      (in_x1),
    .intp_in_base    (in_base),
    .intp_in_scale   (in_scale),
    .intp_in_shift   (in_shift),
    .intp_in_rnd     (in_rnd),
    .intp_in_bypass  (in_byp),
    .intp_out_vld    (out_vld),
    .intp_out_rdy    (out_rdy),
    .intp_out_pd     (out_pd),
    .sat_cnt_clr     (cnt_clr),
    .sat_cnt         (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    logic [BW-1:0] scale;
    logic [5:0]    shift;
    logic [1:0]    rnd;
    logic          byp;
    logic [BW-1:0] base;
    logic          all;
    logic [OW-1:0] exp;
    int            nsat;
  } vec_t;

  localparam int NV = 23;
  vec_t        vt[NV];
  int          total;
  int          bad;
  logic [31:0] m_cnt;

  function automatic vec_t mk(input longint x0, input longint x1, input int scale,
                              input int shift, input int rnd, input int byp,
                              input int base, input int all, input int exp,
                              input int nsat);
    vec_t v;
    v.x0    = x0[DW-1:0];
    v.x1    = x1[DW-1:0];
    v.scale = scale[BW-1:0];
    v.shift = shift[5:0];
    v.rnd   = rnd[1:0];
    v.byp   = byp[0];
    v.base  = base[BW-1:0];
    v.all   = all[0];
    v.exp   = exp[OW-1:0];
    v.nsat  = nsat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_x0   = '0;
    in_x1   = '0;
    in_base = '0;
    for (int l = 0; l < LANES; l++) begin
      if (l == 0 || v.all) begin
        in_x0[l*DW +: DW]   = v.x0;
        in_x1[l*DW +: DW]   = v.x1;
        in_base[l*BW +: BW] = v.base;
      end
    end
    in_scale = v.scale;
    in_shift = v.shift;
    in_rnd   = v.rnd;
    in_byp   = v.byp;
  endtask

  // Sends one beat into an empty pipe with out_rdy high; checks latency,
  // every lane and the counter after delivery.
  task automatic run_vec(input int k);
    int   lat;
    vec_t v;
    logic [OW-1:0] e;
    v = vt[k];
    drive(v);
    in_vld = 1'b1;
    #1;
    chk($sformatf("v%0d_in_rdy", k), in_rdy, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", k), lat, 3);
    for (int l = 0; l < LANES; l++) begin
      e = (l == 0 || v.all) ? v.exp : '0;
      chk($sformatf("v%0d_lane%0d", k, l), out_pd[l*OW +: OW], e);
    end
    @(posedge clk); #1;
    m_cnt = m_cnt + v.nsat;
    chk($sformatf("v%0d_sat_cnt", k), cnt, m_cnt);
    chk($sformatf("v%0d_out_vld_after", k), out_vld, 0);
  endtask

  initial begin
    int   tx, rx, occ, cyc, lat;
    logic in_f, out_f, prev_stall, saw_low;
    logic [LANES*OW-1:0] prev_pd;
    vec_t bv;

    total = 0; bad = 0; m_cnt = 32'd0;
    //        x0                 x1                 scale  sh  rnd byp base    all exp     nsat
    vt[0]  = mk(0,                100,               32768, 16, 0, 0, 5,      0, 55,     0);
    vt[1]  = mk(0,                -3,                32768, 16, 0, 0, 0,      0, -2,     0);
    vt[2]  = mk(0,                -3,                32768, 16, 1, 0, 0,      0, -2,     0);
    vt[3]  = mk(0,                -3,                32768, 16, 2, 0, 0,      0, -2,     0);
    vt[4]  = mk(0,                -1,                32768, 16, 0, 0, 0,      0, -1,     0);
    vt[5]  = mk(0,                -1,                32768, 16, 1, 0, 0,      0, -1,     0);
    vt[6]  = mk(0,                -1,                32768, 16, 2, 0, 0,      0, 0,      0);
    vt[7]  = mk(0,                -3,                32768, 16, 3, 0, 0,      0, -2,     0);
    vt[8]  = mk(0,                3,                 32768, 16, 0, 0, 0,      0, 2,      0);
    vt[9]  = mk(0,                5,                 32768, 16, 2, 0, 0,      0, 2,      0);
    vt[10] = mk(0,                5,                 32768, 16, 0, 0, 0,      0, 3,      0);
    vt[11] = mk(0,                1,                 1,     -20, 0, 0, 32767, 0, 32767,  1);
    vt[12] = mk(0,                1000,              1,     0,  0, 1, -32768, 0, -32768, 0);
    vt[13] = mk(10,               7,                 5,     0,  0, 0, 100,    0, 85,     0);
    vt[14] = mk(0,                -1,                1,     -32, 0, 0, 0,     0, -32768, 1);
    vt[15] = mk(-64'sd274877906944, 64'sd274877906943, 1,   31, 1, 0, 0,      0, 255,    0);
    vt[16] = mk(-64'sd274877906944, 64'sd274877906943, 1,   31, 0, 0, 0,      0, 256,    0);
    vt[17] = mk(0,                64'sd3221225472,   1,     31, 0, 0, -7,     0, -5,     0);
    vt[18] = mk(0,                0,                 0,     0,  0, 1, 65535,  1, 32767,  4);
    vt[19] = mk(0,                1,                 32768, 16, 0, 0, 0,      0, 1,      0);
    vt[20] = mk(0,                1,                 32768, 16, 2, 0, 0,      0, 0,      0);
    vt[21] = mk(0,                -100,              32768, 16, 0, 0, -32768, 0, -32768, 1);
    vt[22] = mk(0,                3,                 1,     1,  2, 0, 0,      0, 2,      0);

    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; cnt_clr = 1'b0;
    drive(vt[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_sat_cnt", cnt, 0);
    chk("rst_in_rdy",  in_rdy, 1);
    chk("rst_out_pd",  out_pd, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) run_vec(k);

    // back-to-back beats with out_rdy pattern 1,0,0,1
    tx = 0; rx = 0; occ = 0; cyc = 0; prev_stall = 1'b0; saw_low = 1'b0; prev_pd = '0;
    while (rx < 8 && cyc < 200) begin
      out_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (tx < 8) begin
        bv = mk(0, 0, 0, 0, 0, 1, 200 + tx, 1, 0, 0);
        drive(bv);
        in_vld = 1'b1;
      end else begin
        in_vld = 1'b0;
      end
      #1;
      chk("b2b_in_rdy", in_rdy, !(occ == 3 && !out_rdy));
      if (!in_rdy) saw_low = 1'b1;
      if (prev_stall) chk("b2b_hold_pd", out_pd, prev_pd);
      in_f  = in_vld & in_rdy;
      out_f = out_vld & out_rdy;
      if (out_f) begin
        chk($sformatf("b2b_beat%0d_lane0", rx), out_pd[0 +: OW], 200 + rx);
        chk($sformatf("b2b_beat%0d_lane3", rx), out_pd[3*OW +: OW], 200 + rx);
        rx++;
      end
      prev_stall = out_vld & !out_rdy;
      prev_pd    = out_pd;
      @(posedge clk); #1;
      occ = occ + int'(in_f) - int'(out_f);
      if (in_f) tx++;
      cyc++;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    chk("b2b_count", rx, 8);
    chk("b2b_saw_rdy_low", saw_low, 1);
    chk("b2b_sat_cnt", cnt, m_cnt);

    // counter clear collides with a 4-lane saturating delivery
    out_rdy = 1'b0;
    drive(vt[18]);
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("clr_beat_arrived", out_vld, 1);
    cnt_clr = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    m_cnt = 32'd0;
    chk("clr_wins_sat_cnt", cnt, 0);
    chk("clr_beat_taken", out_vld, 0);
    run_vec(18);

    // reset with three beats in flight
    out_rdy = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(vt[0]);
      in_vld = 1'b1;
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    chk("inflight_out_vld", out_vld, 1);
    chk("inflight_in_rdy", in_rdy, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_sat_cnt", cnt, 0);
    chk("midrst_in_rdy", in_rdy, 1);
    chk("midrst_out_pd", out_pd, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_rdy = 1'b1; m_cnt = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst_idle%0d", c), out_vld, 0);
    end
    run_vec(11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
